// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot_loader byte-stream RAM writer.
package boot_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int LANE_W         = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_e;

  // Running XOR over every framed byte; the image's trailer must reproduce it.
  function automatic logic [BYTE_W-1:0] csum_fold(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Stream input and RAM write port of the boot loader, seen from the system (master) or loader (slave).
interface boot_loader_if;
  import boot_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic [WORD_W-1:0] mem_a;
  logic [WORD_W-1:0] mem_din;
  logic              mem_rw;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_a, mem_din, mem_rw, cpu_hold, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_a, mem_din, mem_rw, cpu_hold, done, error
  );

endinterface

// File: rtl/boot_loader_byte_packer.sv
// byte_packer: lane counter plus little-endian byte history; `word` is the word completed by the byte on `data`.
module boot_loader_byte_packer
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              last_lane
);

  logic [LANE_W-1:0]        lane_r;
  logic [WORD_W-BYTE_W-1:0] hist_r;

  // Shift accepted bytes in from the top so byte 0 ends up in bits [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_r <= 2'd0;
      hist_r <= 24'd0;
    end else if (clear) begin
      lane_r <= 2'd0;
      hist_r <= 24'd0;
    end else if (load) begin
      lane_r <= lane_r + 2'd1;
      hist_r <= {data, hist_r[WORD_W-BYTE_W-1:BYTE_W]};
    end else begin
      lane_r <= lane_r;
      hist_r <= hist_r;
    end
  end

  assign word      = {data, hist_r};
  assign last_lane = (lane_r == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// boot_loader: framed byte stream -> one-cycle RAM word writes; holds the CPU until the image is complete.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR byte (CHECK state) before releasing the CPU.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [31:0] MAX_WORDS = 32'd8192
) (
  input logic          clk,
  input logic          rst,
  boot_loader_if.slave bus
);

  state_e state_r;
  state_e state_s;

  logic              in_ready_r;
  logic              mem_rw_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              error_r;
  logic [WORD_W-1:0] mem_a_r;
  logic [WORD_W-1:0] mem_din_r;
  logic [WORD_W-1:0] n_r;
  logic [WORD_W-1:0] idx_r;

  logic              fire_s;
  logic              pk_load_s;
  logic              pk_clear_s;
  logic              pk_last_s;
  logic              word_end_s;
  logic [WORD_W-1:0] pk_word_s;

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_e FINAL_ST = CHECK;
  logic [BYTE_W-1:0] csum_r;
`else
  localparam state_e FINAL_ST = DONE;
`endif

  assign fire_s     = bus.in_valid && in_ready_r;
  assign pk_load_s  = fire_s && ((state_r == COUNT) || (state_r == DATA));
  assign pk_clear_s = (state_r == IDLE);
  assign word_end_s = pk_load_s && pk_last_s;

  boot_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .load      (pk_load_s),
    .clear     (pk_clear_s),
    .data      (bus.in_data),
    .word      (pk_word_s),
    .last_lane (pk_last_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; an unreachable encoding falls into ERROR so the CPU stays held.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        state_s = COUNT;
      end
      COUNT: begin
        if (word_end_s) begin
          if (pk_word_s == 32'd0) begin
            state_s = FINAL_ST;
          end else if (pk_word_s > MAX_WORDS) begin
            state_s = ERROR;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = COUNT;
        end
      end
      DATA: begin
        if (word_end_s) begin
          state_s = WRITE;
        end else begin
          state_s = DATA;
        end
      end
      WRITE: begin
        if ((idx_r + 32'd1) == n_r) begin
          state_s = FINAL_ST;
        end else begin
          state_s = DATA;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHECK: begin
        if (fire_s) begin
          if (bus.in_data == csum_r) begin
            state_s = DONE;
          end else begin
            state_s = ERROR;
          end
        end else begin
          state_s = CHECK;
        end
      end
`endif
      DONE:    state_s = DONE;
      ERROR:   state_s = ERROR;
      default: state_s = ERROR;
    endcase
  end

  // Word count, word index and the latched write address/data (held after the strobe).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_r       <= 32'd0;
      idx_r     <= 32'd0;
      mem_a_r   <= 32'd0;
      mem_din_r <= 32'd0;
    end else begin
      if ((state_r == COUNT) && word_end_s) begin
        n_r   <= pk_word_s;
        idx_r <= 32'd0;
      end else if (state_r == WRITE) begin
        idx_r <= idx_r + 32'd1;
      end
      if ((state_r == DATA) && word_end_s) begin
        mem_a_r   <= BASE_ADDR + idx_r;
        mem_din_r <= pk_word_s;
      end
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  // Running XOR over count and payload bytes; the trailer itself is not folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_r <= 8'd0;
    end else if (pk_load_s) begin
      csum_r <= csum_fold(csum_r, bus.in_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // Outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r <= 1'b0;
      mem_rw_r   <= 1'b0;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      in_ready_r <= (state_s == COUNT) || (state_s == DATA) || (state_s == CHECK);
      mem_rw_r   <= (state_s == WRITE);
      cpu_hold_r <= (state_s != DONE);
      done_r     <= (state_s == DONE);
      error_r    <= (state_s == ERROR);
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.mem_a    = mem_a_r;
  assign bus.mem_din  = mem_din_r;
  assign bus.mem_rw   = mem_rw_r;
  assign bus.cpu_hold = cpu_hold_r;
  assign bus.done     = done_r;
  assign bus.error    = error_r;

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream memory writer that fills the processor's word-addressed RAM before execution begins. Accepts a framed byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words, and issues one-cycle write strobes on a port matching the RAM's `a`/`din`/`rw` interface. It is the write-side counterpart of the control unit's instruction-fetch reads, and holds the CPU off until the image is complete.

## Interface
- `BASE_ADDR`, 0: word address of the first word written.
- `MAX_WORDS`, 8192: largest accepted word count (RAM depth).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  byte offered on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_a`  out  32  RAM word address.
- `mem_din`  out  32  RAM write data.
- `mem_rw`  out  1  1 = write strobe (one cycle per word), 0 = idle.
- `cpu_hold`  out  1  1 = CPU must not fetch.
- `done`  out  1  image fully loaded (sticky).
- `error`  out  1  frame rejected (sticky).

## Operation
- Frame: 4-byte word count N (little-endian), then 4·N payload bytes (each word little-endian, byte 0 = bits [7:0]).
- Byte transfer occurs on a rising edge with `in_valid && in_ready`. `in_data` is ignored otherwise.
- States: IDLE → COUNT → DATA ⇄ WRITE → DONE; ERROR is terminal.
- IDLE: one cycle after reset release, then COUNT.
- COUNT: accepts 4 bytes into N. N == 0 → DONE. N > MAX_WORDS → ERROR. Otherwise → DATA, with word index cleared.
- DATA: accepts 4 bytes into the word register. On the 4th byte → WRITE.
- WRITE: `mem_rw`=1, `mem_a`=BASE_ADDR+index, `mem_din`=packed word. Index increments. If index was N−1 → DONE, else → DATA.
- `mem_a` is 32-bit modulo arithmetic. No wrap check beyond the MAX_WORDS test.
- DONE: `done`=1, `cpu_hold`=0. No further bytes accepted until reset.
- ERROR: `error`=1, `cpu_hold` stays 1. No further bytes accepted until reset.
- Reset mid-frame aborts the load. Counters and partial word are cleared. RAM words already written are left as written.

## Timing
- Reset values: `in_ready`=0, `mem_a`=0, `mem_din`=0, `mem_rw`=0, `cpu_hold`=1, `done`=0, `error`=0.
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` to any output.
- `in_ready`=1 exactly in COUNT, DATA and (if enabled) CHECK.
- Write latency: the 4th byte of a word is accepted at edge t. `mem_rw` is high for cycle t..t+1. `in_ready` is 0 for that cycle. The next byte can be accepted at edge t+2.
- Sustained throughput is 4 bytes per 5 cycles.
- `mem_rw` returns to 0 the cycle after WRITE. `mem_a`/`mem_din` hold their last values.
- `done` / `cpu_hold` change on the edge that leaves the final WRITE (or COUNT when N=0).

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined: adds state CHECK.
  - A running XOR is kept over all count and payload bytes.
  - After the final WRITE, or COUNT with N=0, the state is CHECK, which accepts one trailing byte.
  - Trailing byte equal to the XOR → DONE. Any other value → ERROR.
  - `cpu_hold` stays 1 through CHECK, so no code runs from a corrupt image.
- Undefined: no checksum register and no CHECK state. Final WRITE goes directly to DONE.

## Structure
- `boot_loader_pkg`: state enum (IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR), `BYTES_PER_WORD`=4, byte-lane width constants.
- Sub-module `byte_packer`:
  - Functionality: 2-bit lane counter plus 32-bit little-endian shift register.
  - Controls: `load` / `clear` inputs.
  - Outputs: `word` and `last_lane`.
  - Reuse: shared by COUNT and DATA.

## Test plan
- Count 2, payload 78 56 34 12 EF BE AD DE, BASE_ADDR 0 → writes mem[0]=0x12345678, mem[1]=0xDEADBEEF. `done`=1, `cpu_hold`=0.
- Count 0 → no `mem_rw` pulse, `done`=1 one edge after the 4th count byte (without checksum).
- Count 0x00002001 (MAX_WORDS+1) → `error`=1, `in_ready`=0, `cpu_hold`=1, no writes.
- `in_valid` toggled every other cycle mid-word → packed words are unchanged; `in_ready`=0 exactly during each WRITE cycle.
- `rst` asserted after 6 payload bytes, then a full 1-word frame → mem[BASE_ADDR] holds the new word and `done`=1.
- With `BOOT_LOADER_CHECKSUM_EN`: count 1, payload 01 02 03 04, trailer 0x05 → `done`. Trailer 0x00 → `error`, `cpu_hold`=1.
